// File: rtl/stack_pkg.sv
// Shared types for the parametrised LIFO stack engine.
package stack_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_PUSH = 2'b01,
    CMD_POP  = 2'b10,
    CMD_GET  = 2'b11
  } stack_cmd_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } stack_state_e;

endpackage

// File: rtl/stack_regfile.sv
// DEPTH x DATA_W storage: one synchronous write port and
// one combinational read port. Contents are never reset.
module stack_regfile #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 5,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam logic [IDX_W:0] DEPTH_X = (IDX_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Addresses beyond DEPTH only occur on rejected reads.
  assign rdata = ({1'b0, raddr} < DEPTH_X) ? mem_q[raddr] : '0;

endmodule

// File: rtl/stack_param.sv
// Parametrised LIFO stack with valid/ready command handshake.
// Define WRAP_OVERWRITE_EN to make PUSH-when-full overwrite the oldest entry.
module stack_param
  import stack_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 5,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [1:0]        COMMAND,
  input  logic [IDX_W-1:0]  INDEX,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] DOUT,
  output logic              DOUT_VALID,
  output logic [CNT_W-1:0]  COUNT,
  output logic              FULL,
  output logic              EMPTY,
  output logic              ERROR
);

  localparam int AW = CNT_W + 1;
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Operands are each below DEPTH, so one subtraction wraps.
  function automatic logic [IDX_W-1:0] wrap_ptr(
    input logic [AW-1:0] s
  );
    logic [AW-1:0] t;
    t = (s >= DEPTH_A) ? s - DEPTH_A : s;
    return IDX_W'(t);
  endfunction

  stack_state_e state_q, state_d;
  logic cmd_ready;

  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              error_q, error_d;

  stack_cmd_e        cmd;
  logic              acc;
  logic              we;
  logic [AW-1:0]     cnt_x, idx_x, bot_x, rel;
  logic [IDX_W-1:0]  raddr, waddr;
  logic [DATA_W-1:0] rdata;

`ifdef WRAP_OVERWRITE_EN
  logic [IDX_W-1:0] bot_q, bot_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) bot_q <= '0;
    else       bot_q <= bot_d;
  end

  assign bot_x = AW'(bot_q);
`else
  assign bot_x = '0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT) state_d = ST_RUN;
  end

  always_comb begin
    cmd_ready = (state_q == ST_RUN);
  end

  assign cmd   = stack_cmd_e'(COMMAND);
  assign acc   = CMD_VALID && cmd_ready;
  assign cnt_x = AW'(count_q);
  assign idx_x = AW'(INDEX);

  always_comb begin
    rel = cnt_x - AW'(1);
    if (cmd == CMD_GET) rel = rel - idx_x;
    raddr = wrap_ptr(bot_x + rel);
    waddr = wrap_ptr(bot_x + cnt_x);
  end

  always_comb begin
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    error_d      = 1'b0;
    we           = 1'b0;
`ifdef WRAP_OVERWRITE_EN
    bot_d        = bot_q;
`endif
    if (acc) begin
      unique case (cmd)
        CMD_NOP: ;
        CMD_PUSH: begin
          if (!full_q) begin
            we      = 1'b1;
            count_d = count_q + 1'b1;
          end else begin
`ifdef WRAP_OVERWRITE_EN
            we    = 1'b1;
            bot_d = wrap_ptr(bot_x + AW'(1));
`else
            error_d = 1'b1;
`endif
          end
        end
        CMD_POP: begin
          if (!empty_q) begin
            dout_d       = rdata;
            dout_valid_d = 1'b1;
            count_d      = count_q - 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
        CMD_GET: begin
          if (idx_x < cnt_x) begin
            dout_d       = rdata;
            dout_valid_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
      endcase
    end
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      count_q      <= count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      error_q      <= error_d;
    end
  end

  stack_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk   (CLK),
    .we    (we),
    .waddr (waddr),
    .wdata (DIN),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign CMD_READY  = cmd_ready;
  assign DOUT       = dout_q;
  assign DOUT_VALID = dout_valid_q;
  assign COUNT      = count_q;
  assign FULL       = full_q;
  assign EMPTY      = empty_q;
  assign ERROR      = error_q;

endmodule

// File: tb/tb_stack_param.sv
// Directed table-driven bench for stack_param (DATA_W=4, DEPTH=5).
// Expectations follow WRAP_OVERWRITE_EN when the macro is defined.
module tb_stack_param;
  import stack_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] command;
  logic [2:0] index;
  logic [3:0] din;
  logic [3:0] dout;
  logic       dout_valid;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       error;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stack_param dut (
    .CLK        (clk),
    .RESET      (rst),
    .CMD_VALID  (cmd_valid),
    .CMD_READY  (cmd_ready),
    .COMMAND    (command),
    .INDEX      (index),
    .DIN        (din),
    .DOUT       (dout),
    .DOUT_VALID (dout_valid),
    .COUNT      (count),
    .FULL       (full),
    .EMPTY      (empty),
    .ERROR      (error)
  );

  typedef struct {
    logic       v;
    stack_cmd_e cmd;
    logic [2:0] idx;
    logic [3:0] din;
    logic [3:0] dout;
    logic       dv;
    logic [2:0] cnt;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic v, stack_cmd_e c, int idx, int d,
                              int edout, logic edv, int ecnt, logic eerr);
    vec_t r;
    r.v    = v;
    r.cmd  = c;
    r.idx  = 3'(idx);
    r.din  = 4'(d);
    r.dout = 4'(edout);
    r.dv   = edv;
    r.cnt  = 3'(ecnt);
    r.err  = eerr;
    vecs.push_back(r);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(string tag);
    chk({tag, ".count"}, 32'(count), 0);
    chk({tag, ".empty"}, 32'(empty), 1);
    chk({tag, ".full"}, 32'(full), 0);
    chk({tag, ".dout"}, 32'(dout), 0);
    chk({tag, ".dv"}, 32'(dout_valid), 0);
    chk({tag, ".err"}, 32'(error), 0);
    chk({tag, ".ready"}, 32'(cmd_ready), 0);
  endtask

  initial begin
    int ovf_err;
    int get4;
    int p0;
    int last;
`ifdef WRAP_OVERWRITE_EN
    ovf_err = 0; get4 = 2; p0 = 6;
`else
    ovf_err = 1; get4 = 1; p0 = 5;
`endif
    last = p0 - 4;

    for (int k = 1; k <= 5; k++) add(1, CMD_PUSH, 0, k, 0, 0, k, 0);
    for (int k = 5; k >= 1; k--) add(1, CMD_POP, 0, 0, k, 1, k - 1, 0);
    add(1, CMD_POP, 0, 0, 1, 0, 0, 1);
    add(1, CMD_GET, 0, 0, 1, 0, 0, 1);
    add(1, CMD_PUSH, 0, 7, 1, 0, 1, 0);
    add(1, CMD_PUSH, 0, 8, 1, 0, 2, 0);
    add(1, CMD_PUSH, 0, 9, 1, 0, 3, 0);
    add(1, CMD_GET, 0, 0, 9, 1, 3, 0);
    add(1, CMD_GET, 2, 0, 7, 1, 3, 0);
    add(1, CMD_GET, 3, 0, 7, 0, 3, 1);
    add(1, CMD_GET, 1, 0, 8, 1, 3, 0);
    add(1, CMD_POP, 0, 0, 9, 1, 2, 0);
    add(1, CMD_POP, 0, 0, 8, 1, 1, 0);
    add(1, CMD_POP, 0, 0, 7, 1, 0, 0);
    for (int k = 1; k <= 5; k++) add(1, CMD_PUSH, 0, k, 7, 0, k, 0);
    add(1, CMD_PUSH, 0, 6, 7, 0, 5, 1'(ovf_err));
    add(1, CMD_GET, 4, 0, get4, 1, 5, 0);
    for (int k = 0; k < 5; k++) add(1, CMD_POP, 0, 0, p0 - k, 1, 4 - k, 0);
    add(1, CMD_PUSH, 0, 10, last, 0, 1, 0);
    add(1, CMD_POP, 0, 0, 10, 1, 0, 0);
    add(1, CMD_PUSH, 0, 11, 10, 0, 1, 0);
    add(1, CMD_GET, 0, 0, 11, 1, 1, 0);
    add(1, CMD_NOP, 0, 0, 11, 0, 1, 0);
    add(0, CMD_PUSH, 0, 15, 11, 0, 1, 0);
    add(0, CMD_POP, 0, 0, 11, 0, 1, 0);

    rst = 1'b1;
    cmd_valid = 1'b0;
    command = 2'b00;
    index = '0;
    din = '0;
    #12;
    chk_reset("reset");

    @(negedge clk);
    rst = 1'b0;
    cmd_valid = 1'b1;
    command = CMD_PUSH;
    din = 4'hF;
    #1;
    chk("init.ready", 32'(cmd_ready), 0);
    @(posedge clk);
    #1;
    chk("run.ready", 32'(cmd_ready), 1);
    chk("init.count", 32'(count), 0);
    chk("init.empty", 32'(empty), 1);

    for (int i = 0; i < vecs.size(); i++) begin
      string t;
      t = $sformatf("v%0d", i);
      @(negedge clk);
      cmd_valid = vecs[i].v;
      command = vecs[i].cmd;
      index = vecs[i].idx;
      din = vecs[i].din;
      @(posedge clk);
      #1;
      chk({t, ".dout"}, 32'(dout), 32'(vecs[i].dout));
      chk({t, ".dv"}, 32'(dout_valid), 32'(vecs[i].dv));
      chk({t, ".count"}, 32'(count), 32'(vecs[i].cnt));
      chk({t, ".err"}, 32'(error), 32'(vecs[i].err));
      chk({t, ".full"}, 32'(full), 32'(vecs[i].cnt == 3'd5));
      chk({t, ".empty"}, 32'(empty), 32'(vecs[i].cnt == 3'd0));
      chk({t, ".ready"}, 32'(cmd_ready), 1);
    end

    @(negedge clk);
    cmd_valid = 1'b1;
    command = CMD_PUSH;
    din = 4'h3;
    @(negedge clk);
    command = CMD_POP;
    @(posedge clk);
    #1;
    chk("mid.dout", 32'(dout), 3);
    chk("mid.dv", 32'(dout_valid), 1);
    chk("mid.count", 32'(count), 1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("midrst");

    @(negedge clk);
    rst = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk("rel.ready", 32'(cmd_ready), 0);
    @(posedge clk);
    #1;
    chk("rel2.ready", 32'(cmd_ready), 1);
    chk("rel2.count", 32'(count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_param.md
Name: stack_param

Overview:
- Parametrised LIFO stack engine, successor to the fixed 4-bit/5-entry stack.
- Same 2-bit command set: NOP, PUSH, POP, GET.
- Generalised to arbitrary width and depth, with separate input and output data buses and a valid/ready command handshake.
- Registered read data, occupancy flags and error reporting.
- Sits between a command-issuing controller and any consumer of popped or peeked data.

Parameters:
DATA_W, 4, width of each stack entry in bits
DEPTH, 5, number of entries (must be at least 2)
IDX_W, $clog2(DEPTH), width of INDEX and derived pointers
CNT_W, $clog2(DEPTH+1), width of COUNT

Ports:
CLK  input  1  rising-edge clock
RESET  input  1  asynchronous, active-high reset
CMD_VALID  input  1  command present this cycle
CMD_READY  output  1  block accepts command this cycle
COMMAND  input  2  00 NOP, 01 PUSH, 10 POP, 11 GET
INDEX  input  IDX_W  GET depth below top (0 = top)
DIN  input  DATA_W  push data
DOUT  output  DATA_W  registered POP/GET result
DOUT_VALID  output  1  one-cycle pulse, DOUT holds new result
COUNT  output  CNT_W  current occupancy, 0..DEPTH
FULL  output  1  COUNT == DEPTH
EMPTY  output  1  COUNT == 0
ERROR  output  1  one-cycle pulse on a rejected command

Behaviour:
- Reset (async assert, sync release):
  - COUNT=0, EMPTY=1, FULL=0, DOUT=0, DOUT_VALID=0, ERROR=0, CMD_READY=0.
  - Storage contents need not be cleared.
  - Reset mid-operation discards any in-flight result.
- Two-state FSM:
  - INIT: entered on reset. Spends exactly one cycle with CMD_READY=0, then goes to RUN.
  - RUN: CMD_READY=1 permanently.
- Commands are accepted only when CMD_VALID && CMD_READY. NOP or no handshake leaves all state unchanged.
- PUSH:
  - If not FULL, write DIN at the top position and increment COUNT.
  - No DOUT_VALID pulse.
- POP:
  - If not EMPTY, DOUT <= top entry and decrement COUNT, all in the same edge.
  - DOUT_VALID pulses the following cycle (1-cycle latency from acceptance edge to visible data).
- GET:
  - If INDEX < COUNT, DOUT <= entry INDEX positions below the top. Stack is unchanged.
  - DOUT_VALID pulses with the same latency as POP.
- Errors (ERROR pulses for one cycle, aligned with where DOUT_VALID would be; stack and DOUT unchanged):
  - POP when EMPTY.
  - GET with INDEX >= COUNT, including any GET when EMPTY.
  - PUSH when FULL (only without WRAP_OVERWRITE_EN).
- DOUT holds its last value between results and is never tri-stated.
- FULL/EMPTY/COUNT are registered and reflect the state after the last accepted command.
- Back-to-back commands every cycle are supported. PUSH then POP on consecutive cycles returns the just-pushed value.
- Pointer arithmetic is modulo DEPTH, with explicit compare-and-wrap. The `%` operator is not used on non-power-of-2 DEPTH.

Optional Feature:
WRAP_OVERWRITE_EN
- Defined: storage is a circular ring with top and bottom pointers.
  - PUSH when FULL overwrites the oldest (bottom) entry and advances the bottom pointer.
  - COUNT stays at DEPTH; no ERROR.
  - A subsequent POP sequence returns the newest DEPTH values only.
- Undefined: PUSH when FULL is rejected with an ERROR pulse, and no bottom pointer is synthesised.
- POP/GET error rules are identical in both builds.

Decomposition:
- Package stack_pkg:
  - enum type stack_cmd_e (CMD_NOP=2'b00, CMD_PUSH=2'b01, CMD_POP=2'b10, CMD_GET=2'b11).
  - FSM state enum stack_state_e (ST_INIT, ST_RUN).
- Sub-module stack_regfile:
  - DEPTH x DATA_W register array, one synchronous write port, one combinational read port addressed by IDX_W pointer.
  - Instantiated once by stack_param.
- Pointer/count logic and FSM stay in the top module.

Test Plan:
- Reset then idle:
  - Assert RESET mid-cycle -> all outputs take reset values immediately, without waiting for a clock edge.
  - CMD_READY=0 for the first cycle after release, then 1.
- Fill and drain (DATA_W=4, DEPTH=5):
  - PUSH 1,2,3,4,5 -> FULL=1, COUNT=5.
  - Five POPs -> DOUT 5,4,3,2,1, each with DOUT_VALID one cycle after acceptance.
  - Final state EMPTY=1.
- GET:
  - After PUSH 7,8,9: GET INDEX=0 -> 9; INDEX=2 -> 7; INDEX=3 -> ERROR pulse, DOUT stays 7.
  - COUNT stays 3 throughout.
- Underflow:
  - POP on empty -> ERROR=1 for one cycle, DOUT_VALID=0, COUNT stays 0.
- Overflow, both builds (stack pre-filled with 1..5, then PUSH 6):
  - Without WRAP_OVERWRITE_EN: ERROR, and a later POP returns 5.
  - With it: no ERROR, and POPs return 6,5,4,3,2.
- Back-to-back and reset mid-stream:
  - PUSH A, POP, PUSH B, GET 0 on consecutive cycles -> DOUT A then B.
  - RESET asserted during a POP result cycle -> DOUT_VALID forced 0, COUNT=0.
